asym_fifo_ctrl: RTL and testbench
=================================

# asym_fifo_ctrl

- Pointer and flag controller for an asymmetric-width FIFO built on an external single-clock dual-port RAM.
- The wide/narrow ratio (2^RATIO_LOG2) and the direction (wide write/narrow read, or narrow write/wide read) are set by parameters.
- Provides registered full/empty flags, an occupancy level, overflow/underflow error pulses and a synchronous flush.
- Gated reads and writes are correct under every combination of simultaneous events.

## Interface
- ADDR_WIDTH, 4: wide-word address width; capacity is 2^ADDR_WIDTH wide words.
- RATIO_LOG2, 1: log2 of narrow units per wide word; legal range 1..3.
- WIDE_WR, 1: 1 = write wide, read narrow; 0 = write narrow, read wide.
- clk  in  1  clock; all logic on the rising edge.
- arst_n  in  1  reset, asynchronous, active-low.
- clr  in  1  synchronous flush; has priority over wr_en and rd_en.
- wr_en  in  1  write request, one word of the write-side width.
- rd_en  in  1  read request, one word of the read-side width.
- wr_addr  out  ADDR_WIDTH  RAM wide-word address for the current write.
- wr_sub  out  RATIO_LOG2  narrow lane within wr_addr; constant 0 when WIDE_WR=1.
- rd_addr  out  ADDR_WIDTH  RAM wide-word address for the current read.
- rd_sub  out  RATIO_LOG2  narrow lane within rd_addr; constant 0 when WIDE_WR=0.
- full  out  1  the next write would overflow.
- empty  out  1  the next read would underflow.
- level  out  ADDR_WIDTH+RATIO_LOG2+1  occupancy in narrow units.
- wr_err  out  1  one-cycle pulse: wr_en asserted while full.
- rd_err  out  1  one-cycle pulse: rd_en asserted while empty.

## Operation
- Both pointers count in narrow units (NP = ADDR_WIDTH+RATIO_LOG2+1 bits, MSB is the wrap bit).
- The wide-side pointer steps by 2^RATIO_LOG2; the narrow-side pointer steps by 1.
- Address mapping: wr_addr/wr_sub = wr_ptr[NP-2:RATIO_LOG2] / wr_ptr[RATIO_LOG2-1:0]; rd_addr/rd_sub are mapped the same way from rd_ptr.
- Wide-side pointer low bits are always 0.
- Capacity C = 2^(ADDR_WIDTH+RATIO_LOG2). level = wr_ptr - rd_ptr, modulo 2^NP, giving range 0..C.
- WIDE_WR=1: full when level > C - 2^RATIO_LOG2; empty when level == 0.
- WIDE_WR=0: full when level == C; empty when level < 2^RATIO_LOG2.
- Accept rules:
  - Write is accepted iff wr_en && !full.
  - Read is accepted iff rd_en && !empty.
  - Both are evaluated against the current registered flags, independently.
- Simultaneous accepted read and write:
  - Both pointers advance.
  - level changes by the write step minus the read step.
  - Flags are recomputed from the next pointers.
- A read on full and a write on empty are each handled by its own rule above: no bypass, no pass-through.
- Rejected requests leave all state unchanged and raise the matching err pulse.
- clr: pointers and level go to 0, empty=1, full=0, err pulses forced to 0; any wr_en/rd_en in that cycle is ignored.
- Pointer wrap is natural modulo-2^NP rollover; the address outputs wrap from 2^ADDR_WIDTH-1 to 0.

## Timing
- Reset values: wr_addr=0, wr_sub=0, rd_addr=0, rd_sub=0, full=0, empty=1, level=0, wr_err=0, rd_err=0.
- arst_n is asserted mid-operation: all state returns to the reset values immediately, regardless of clk.
- The RAM write uses wr_addr/wr_sub in the same cycle as an accepted wr_en.
- rd_addr/rd_sub point at the oldest unread word whenever empty=0. Read data timing belongs to the RAM wrapper.
- Pointers, level, full and empty are all registered. An operation accepted at edge N is visible after edge N.
- Empty deasserts one cycle after the first write that supplies at least one read word.
- err pulses are registered and appear the cycle after the offending request.
- No combinational path from wr_en/rd_en to any output.

## Structure
- asym_fifo_pkg:
  - NP width function and capacity/step constants derived from ADDR_WIDTH and RATIO_LOG2.
  - Mode enum: WIDE_WRITE and NARROW_WRITE.
- One sub-module, asym_fifo_ptr: a pointer register with a parameterised step, increment enable and sync clear. It is instantiated twice, with steps 1 and 2^RATIO_LOG2 assigned by WIDE_WR.
- Top level holds level subtraction, flag next-state logic and err registers.

## Test plan
- AW=2, R=2, WIDE_WR=1, reset:
  - 4 writes give level 4, 8, 12, 16 and full=1 after the 4th.
  - A 5th write gives a wr_err pulse and level stays 16.
  - Reads at 16 narrow units: full stays 1 at levels 15 and 14, deasserts at 12 (after the 4th read).
  - 16 reads in total give empty=1 with rd_sub cycling 0,1,2,3 per rd_addr.
- AW=2, R=2, WIDE_WR=0:
  - Writes of 3 narrow units leave empty=1; the 4th sets empty=0 with rd_addr=0.
  - One read gives level 0 and empty=1.
- Simultaneous rd_en+wr_en on empty (WIDE_WR=1): write accepted, rd_err pulses, level becomes 4.
- Simultaneous rd_en+wr_en on full (WIDE_WR=0): read accepted, wr_err pulses, level goes from 16 to 12.
- Wrap-around: stream 40 wide writes and 160 narrow reads interleaved at level ≤ 8.
  - Addresses wrap 3 to 0.
  - Read order matches write order, checked by scoreboard.
  - Flags never mismatch the reference model.
- Flush and reset:
  - clr at level 9 with wr_en=1 gives level 0, empty=1, no err.
  - arst_n pulsed mid-stream gives all outputs at reset values before the next edge.

Source files
------------

// File: rtl/asym_fifo_pkg.sv
// Shared sizing helpers and mode encoding for the asymmetric FIFO controller.
package asym_fifo_pkg;

   typedef enum logic {
      NARROW_WRITE = 1'b0,
      WIDE_WRITE   = 1'b1
   } mode_e;

   // Pointer width in narrow units, including the wrap bit.
   function automatic int unsigned ptr_width(input int unsigned aw, input int unsigned r);
      return aw + r + 1;
   endfunction

   // Capacity in narrow units.
   function automatic int unsigned capacity(input int unsigned aw, input int unsigned r);
      return 32'd1 << (aw + r);
   endfunction

   // Narrow units per wide word.
   function automatic int unsigned wide_step(input int unsigned r);
      return 32'd1 << r;
   endfunction

endpackage

// File: rtl/asym_fifo_ptr.sv
// Narrow-unit pointer register with a fixed step, increment enable and sync clear.
module asym_fifo_ptr
   import asym_fifo_pkg::*;
#(
   parameter int unsigned NP   = 5,
   parameter int unsigned STEP = 1
) (
   input  logic          clk,
   input  logic          arst_n,
   input  logic          clr,
   input  logic          inc,
   output logic [NP-1:0] ptr,
   output logic [NP-1:0] ptr_nxt
);

   // Value the pointer takes at the next edge when not cleared.
   always_comb begin
      ptr_nxt = ptr;
      if (inc) ptr_nxt = ptr + NP'(STEP);
   end

   // Pointer register; wraps naturally modulo 2^NP.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n)  ptr <= '0;
      else if (clr) ptr <= '0;
      else          ptr <= ptr_nxt;
   end

endmodule

// File: rtl/asym_fifo_ctrl.sv
// Pointer and flag controller for an asymmetric-width FIFO on an external dual-port RAM.
module asym_fifo_ctrl
   import asym_fifo_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 4,
   parameter int unsigned RATIO_LOG2 = 1,
   parameter int unsigned WIDE_WR    = 1
) (
   input  logic                           clk,
   input  logic                           arst_n,
   input  logic                           clr,
   input  logic                           wr_en,
   input  logic                           rd_en,
   output logic [ADDR_WIDTH-1:0]          wr_addr,
   output logic [RATIO_LOG2-1:0]          wr_sub,
   output logic [ADDR_WIDTH-1:0]          rd_addr,
   output logic [RATIO_LOG2-1:0]          rd_sub,
   output logic                           full,
   output logic                           empty,
   output logic [ADDR_WIDTH+RATIO_LOG2:0] level,
   output logic                           wr_err,
   output logic                           rd_err
);

   localparam int unsigned NP      = ptr_width(ADDR_WIDTH, RATIO_LOG2);
   localparam int unsigned CAP     = capacity(ADDR_WIDTH, RATIO_LOG2);
   localparam int unsigned WSTEP   = wide_step(RATIO_LOG2);
   localparam mode_e       MODE    = (WIDE_WR != 0) ? WIDE_WRITE : NARROW_WRITE;
   localparam int unsigned WR_STEP = (MODE == WIDE_WRITE) ? WSTEP : 1;
   localparam int unsigned RD_STEP = (MODE == WIDE_WRITE) ? 1 : WSTEP;

   logic          wr_acc, rd_acc;
   logic [NP-1:0] wr_ptr, wr_ptr_nxt, rd_ptr, rd_ptr_nxt, level_nxt;
   logic          full_nxt, empty_nxt;

   assign wr_acc = wr_en && !full;
   assign rd_acc = rd_en && !empty;

   asym_fifo_ptr #(.NP(NP), .STEP(WR_STEP)) u_wr_ptr (
      .clk     (clk),
      .arst_n  (arst_n),
      .clr     (clr),
      .inc     (wr_acc),
      .ptr     (wr_ptr),
      .ptr_nxt (wr_ptr_nxt)
   );

   asym_fifo_ptr #(.NP(NP), .STEP(RD_STEP)) u_rd_ptr (
      .clk     (clk),
      .arst_n  (arst_n),
      .clr     (clr),
      .inc     (rd_acc),
      .ptr     (rd_ptr),
      .ptr_nxt (rd_ptr_nxt)
   );

   assign wr_addr = wr_ptr[NP-2:RATIO_LOG2];
   assign rd_addr = rd_ptr[NP-2:RATIO_LOG2];
   assign wr_sub  = (MODE == WIDE_WRITE)   ? '0 : wr_ptr[RATIO_LOG2-1:0];
   assign rd_sub  = (MODE == NARROW_WRITE) ? '0 : rd_ptr[RATIO_LOG2-1:0];

   // Flags are derived from the post-edge pointers so they are ready the cycle after an operation.
   always_comb begin
      level_nxt = wr_ptr_nxt - rd_ptr_nxt;
      full_nxt  = 1'b0;
      empty_nxt = 1'b1;
      if (MODE == WIDE_WRITE) begin
         full_nxt  = level_nxt > NP'(CAP - WSTEP);
         empty_nxt = level_nxt == '0;
      end else begin
         full_nxt  = level_nxt == NP'(CAP);
         empty_nxt = level_nxt < NP'(WSTEP);
      end
   end

   // Registered level, flags and error pulses; flush wins over any request.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         level  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
         wr_err <= 1'b0;
         rd_err <= 1'b0;
      end else if (clr) begin
         level  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
         wr_err <= 1'b0;
         rd_err <= 1'b0;
      end else begin
         level  <= level_nxt;
         full   <= full_nxt;
         empty  <= empty_nxt;
         wr_err <= wr_en && full;
         rd_err <= rd_en && empty;
      end
   end

endmodule

// File: tb/tb_asym_fifo_ctrl.sv
// Directed bench for asym_fifo_ctrl: one wide-write and one narrow-write instance, AW=2, R=2.
module tb_asym_fifo_ctrl;

   logic clk = 1'b0;
   logic arst_n;

   logic       a_clr, a_wr, a_rd;
   logic [1:0] a_wr_addr, a_wr_sub, a_rd_addr, a_rd_sub;
   logic       a_full, a_empty, a_wr_err, a_rd_err;
   logic [4:0] a_level;

   logic       b_clr, b_wr, b_rd;
   logic [1:0] b_wr_addr, b_wr_sub, b_rd_addr, b_rd_sub;
   logic       b_full, b_empty, b_wr_err, b_rd_err;
   logic [4:0] b_level;

   int checks = 0;
   int errors = 0;

   logic [7:0] mem [4][4];
   logic [7:0] q [$];
   logic [7:0] exp_data;
   int m_wp, m_rp, m_level, nw, nr, wraps, prev_wa;
   logic w, r, wacc, racc;

   always #5 clk = ~clk;

   asym_fifo_ctrl #(.ADDR_WIDTH(2), .RATIO_LOG2(2), .WIDE_WR(1)) u_a (
      .clk(clk), .arst_n(arst_n), .clr(a_clr), .wr_en(a_wr), .rd_en(a_rd),
      .wr_addr(a_wr_addr), .wr_sub(a_wr_sub), .rd_addr(a_rd_addr), .rd_sub(a_rd_sub),
      .full(a_full), .empty(a_empty), .level(a_level), .wr_err(a_wr_err), .rd_err(a_rd_err)
   );

   asym_fifo_ctrl #(.ADDR_WIDTH(2), .RATIO_LOG2(2), .WIDE_WR(0)) u_b (
      .clk(clk), .arst_n(arst_n), .clr(b_clr), .wr_en(b_wr), .rd_en(b_rd),
      .wr_addr(b_wr_addr), .wr_sub(b_wr_sub), .rd_addr(b_rd_addr), .rd_sub(b_rd_sub),
      .full(b_full), .empty(b_empty), .level(b_level), .wr_err(b_wr_err), .rd_err(b_rd_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick_a(input logic wv, input logic rv, input logic cv);
      a_wr = wv; a_rd = rv; a_clr = cv;
      @(posedge clk); #1;
      a_wr = 1'b0; a_rd = 1'b0; a_clr = 1'b0;
   endtask

   task automatic tick_b(input logic wv, input logic rv, input logic cv);
      b_wr = wv; b_rd = rv; b_clr = cv;
      @(posedge clk); #1;
      b_wr = 1'b0; b_rd = 1'b0; b_clr = 1'b0;
   endtask

   initial begin
      arst_n = 1'b0;
      a_clr = 1'b0; a_wr = 1'b0; a_rd = 1'b0;
      b_clr = 1'b0; b_wr = 1'b0; b_rd = 1'b0;
      #12;
      chk("rst_a_wr_addr", a_wr_addr, 0);
      chk("rst_a_wr_sub",  a_wr_sub,  0);
      chk("rst_a_rd_addr", a_rd_addr, 0);
      chk("rst_a_rd_sub",  a_rd_sub,  0);
      chk("rst_a_full",    a_full,    0);
      chk("rst_a_empty",   a_empty,   1);
      chk("rst_a_level",   a_level,   0);
      chk("rst_a_wr_err",  a_wr_err,  0);
      chk("rst_a_rd_err",  a_rd_err,  0);
      chk("rst_b_empty",   b_empty,   1);
      chk("rst_b_level",   b_level,   0);
      arst_n = 1'b1;
      @(posedge clk); #1;

      // A: four wide writes fill the FIFO
      for (int k = 1; k <= 4; k++) begin
         tick_a(1'b1, 1'b0, 1'b0);
         chk("a_fill_level", a_level, 4 * k);
         chk("a_fill_full",  a_full,  (k == 4));
         chk("a_fill_empty", a_empty, 0);
         chk("a_fill_waddr", a_wr_addr, k % 4);
         chk("a_fill_wsub",  a_wr_sub, 0);
      end
      tick_a(1'b1, 1'b0, 1'b0);
      chk("a_ovf_wr_err", a_wr_err, 1);
      chk("a_ovf_level",  a_level, 16);
      chk("a_ovf_full",   a_full, 1);
      tick_a(1'b0, 1'b0, 1'b0);
      chk("a_ovf_pulse_end", a_wr_err, 0);

      // A: sixteen narrow reads drain it
      for (int i = 0; i < 16; i++) begin
         chk("a_drain_raddr", a_rd_addr, i / 4);
         chk("a_drain_rsub",  a_rd_sub,  i % 4);
         tick_a(1'b0, 1'b1, 1'b0);
         chk("a_drain_level", a_level, 15 - i);
         chk("a_drain_full",  a_full,  ((15 - i) > 12));
         chk("a_drain_empty", a_empty, (i == 15));
      end
      tick_a(1'b0, 1'b1, 1'b0);
      chk("a_udf_rd_err", a_rd_err, 1);
      chk("a_udf_level",  a_level, 0);
      chk("a_udf_raddr",  a_rd_addr, 0);

      // A: simultaneous read+write on empty
      tick_a(1'b1, 1'b1, 1'b0);
      chk("a_sim_level",  a_level, 4);
      chk("a_sim_rd_err", a_rd_err, 1);
      chk("a_sim_wr_err", a_wr_err, 0);
      chk("a_sim_empty",  a_empty, 0);
      for (int i = 0; i < 4; i++) tick_a(1'b0, 1'b1, 1'b0);
      chk("a_sim_drain_level", a_level, 0);
      chk("a_sim_drain_empty", a_empty, 1);

      // B: narrow writes, wide reads
      for (int k = 1; k <= 3; k++) begin
         tick_b(1'b1, 1'b0, 1'b0);
         chk("b_part_level", b_level, k);
         chk("b_part_empty", b_empty, 1);
         chk("b_part_wsub",  b_wr_sub, k);
      end
      tick_b(1'b1, 1'b0, 1'b0);
      chk("b_word_level", b_level, 4);
      chk("b_word_empty", b_empty, 0);
      chk("b_word_raddr", b_rd_addr, 0);
      chk("b_word_rsub",  b_rd_sub, 0);
      tick_b(1'b0, 1'b1, 1'b0);
      chk("b_rd_level", b_level, 0);
      chk("b_rd_empty", b_empty, 1);
      chk("b_rd_raddr", b_rd_addr, 1);
      for (int k = 1; k <= 16; k++) begin
         tick_b(1'b1, 1'b0, 1'b0);
         chk("b_fill_full", b_full, (k == 16));
      end
      chk("b_fill_level", b_level, 16);
      tick_b(1'b1, 1'b1, 1'b0);
      chk("b_sim_level",  b_level, 12);
      chk("b_sim_full",   b_full, 0);
      chk("b_sim_wr_err", b_wr_err, 1);
      chk("b_sim_rd_err", b_rd_err, 0);

      // A: streaming wrap-around against a reference model and scoreboard
      m_wp = 20; m_rp = 20; m_level = 0; nw = 0; nr = 0; wraps = 0; prev_wa = -1;
      for (int cyc = 0; cyc < 400; cyc++) begin
         if (nw >= 40 && nr >= 160) break;
         w    = (nw < 40) && (m_level <= 4);
         r    = (nr < 160);
         wacc = w && !(m_level > 12);
         racc = r && (m_level != 0);
         if (wacc) begin
            chk("wrap_waddr", a_wr_addr, (m_wp / 4) % 4);
            for (int l = 0; l < 4; l++) begin
               mem[a_wr_addr][l] = {nw[5:0], l[1:0]};
               q.push_back({nw[5:0], l[1:0]});
            end
            if (prev_wa == 3 && a_wr_addr == 2'd0) wraps++;
            prev_wa = int'(a_wr_addr);
         end
         if (racc) begin
            chk("wrap_raddr", a_rd_addr, (m_rp / 4) % 4);
            chk("wrap_rsub",  a_rd_sub,  m_rp % 4);
            exp_data = q.pop_front();
            chk("wrap_data", mem[a_rd_addr][a_rd_sub], exp_data);
         end
         tick_a(w, r, 1'b0);
         if (wacc) begin m_wp = (m_wp + 4) % 32; m_level += 4; nw++; end
         if (racc) begin m_rp = (m_rp + 1) % 32; m_level -= 1; nr++; end
         chk("wrap_level",  a_level, m_level);
         chk("wrap_full",   a_full,  (m_level > 12));
         chk("wrap_empty",  a_empty, (m_level == 0));
         chk("wrap_rd_err", a_rd_err, (r && !racc));
         chk("wrap_wr_err", a_wr_err, (w && !wacc));
      end
      chk("wrap_done",  (nw == 40 && nr == 160), 1);
      chk("wrap_count", wraps, 10);

      // A: flush at level 9 with a concurrent write
      for (int i = 0; i < 3; i++) tick_a(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) tick_a(1'b0, 1'b1, 1'b0);
      chk("clr_pre_level", a_level, 9);
      tick_a(1'b1, 1'b0, 1'b1);
      chk("clr_level",  a_level, 0);
      chk("clr_empty",  a_empty, 1);
      chk("clr_full",   a_full, 0);
      chk("clr_wr_err", a_wr_err, 0);
      chk("clr_rd_err", a_rd_err, 0);
      chk("clr_waddr",  a_wr_addr, 0);
      chk("clr_raddr",  a_rd_addr, 0);

      // B: flush while full with a write pending must not raise wr_err
      for (int i = 0; i < 4; i++) tick_b(1'b1, 1'b0, 1'b0);
      chk("b_clr_pre_full", b_full, 1);
      tick_b(1'b1, 1'b0, 1'b1);
      chk("b_clr_wr_err", b_wr_err, 0);
      chk("b_clr_level",  b_level, 0);
      chk("b_clr_full",   b_full, 0);

      // Asynchronous reset between edges
      tick_a(1'b1, 1'b0, 1'b0);
      a_wr = 1'b1; b_wr = 1'b1;
      @(posedge clk); #1;
      a_wr = 1'b0; b_wr = 1'b0;
      chk("arst_pre_level", a_level, 8);
      #2 arst_n = 1'b0;
      #1;
      chk("arst_a_level", a_level, 0);
      chk("arst_a_empty", a_empty, 1);
      chk("arst_a_waddr", a_wr_addr, 0);
      chk("arst_b_level", b_level, 0);
      chk("arst_b_wsub",  b_wr_sub, 0);
      chk("arst_b_empty", b_empty, 1);
      #1 arst_n = 1'b1;
      tick_a(1'b1, 1'b0, 1'b0);
      chk("arst_recover_level", a_level, 4);
      chk("arst_recover_waddr", a_wr_addr, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
